// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Memory-access pipeline stage. Non-memory instructions pass their
//            register writeback straight through. Loads and stores are
//            serialised into byte transfers on an 8-bit arbitrated memory
//            port. The pipeline is held until the access completes. Load
//            results are sign- or zero-extended by RISC-V funct3.
// Config   : MEM_ALIGN_CHECK_EN - when defined, misaligned halfword and word
//            accesses are refused. Misalign is flagged and no traffic is
//            issued. When undefined, misaligned accesses proceed bytewise.
// Ports    : clk, rst (sync, active-high), rdy (global ready, low = freeze)
//            we_in/waddr_in/wdata_in          writeback request from EX
//            ma_we_in/ma_re_in/ma_width_in    store/load request, funct3
//            ma_addr_in/ma_wdata_in           byte address, store data
//            we/waddr/wdata                   writeback to MEM/WB latch
//            stall_req                        pipeline hold request
//            mem_req/mem_wr/mem_addr/mem_dout byte-wide memory request
//            mem_gnt/mem_din                  accept strobe, read byte (+1)
//            misalign                         misaligned-access flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        we_in,
    input  logic [4:0]  waddr_in,
    input  logic [31:0] wdata_in,
    input  logic        ma_we_in,
    input  logic        ma_re_in,
    input  logic [2:0]  ma_width_in,
    input  logic [31:0] ma_addr_in,
    input  logic [31:0] ma_wdata_in,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        stall_req,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din,
    output logic        misalign
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  idx_q;        // bytes granted so far
    logic        store_q;
    logic [2:0]  width_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [31:0] ldata_q;
    logic [4:0]  waddr_q;
    logic        rd_pend_q;    // a read was accepted last cycle; data on mem_din now

    logic        w_req;
    logic        w_misaligned;
    logic        w_start;
    logic [2:0]  w_n_q;
    logic        w_last;
    logic [1:0]  w_cap_idx;
    logic [7:0]  w_store_byte;
    logic [31:0] w_ld_ext;

    function automatic logic [2:0] byte_count(input logic [2:0] width);
        case (width[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign w_req = ma_we_in | ma_re_in;

`ifdef MEM_ALIGN_CHECK_EN
    logic [2:0] w_n_in;
    assign w_n_in       = byte_count(ma_width_in);
    assign w_misaligned = ((w_n_in == 3'd2) && ma_addr_in[0]) ||
                          ((w_n_in == 3'd4) && (ma_addr_in[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_start      = w_req & ~w_misaligned;
    assign w_n_q        = byte_count(width_q);
    assign w_last       = (idx_q == (w_n_q - 3'd1));
    // idx has already advanced past the byte now arriving; for idx=4 the
    // 2-bit wrap yields 3, the top byte.
    assign w_cap_idx    = idx_q[1:0] - 2'd1;
    assign w_store_byte = sdata_q[{idx_q[1:0], 3'b000} +: 8];

    always_comb begin
        w_ld_ext = ldata_q;
        case (width_q)
            3'b000:  w_ld_ext = {{24{ldata_q[7]}},  ldata_q[7:0]};
            3'b001:  w_ld_ext = {{16{ldata_q[15]}}, ldata_q[15:0]};
            3'b100:  w_ld_ext = {24'd0, ldata_q[7:0]};
            3'b101:  w_ld_ext = {16'd0, ldata_q[15:0]};
            default: w_ld_ext = ldata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            store_q   <= 1'b0;
            width_q   <= 3'd0;
            addr_q    <= 32'd0;
            sdata_q   <= 32'd0;
            ldata_q   <= 32'd0;
            waddr_q   <= 5'd0;
            rd_pend_q <= 1'b0;
        end else if (rdy) begin
            if (rd_pend_q) begin
                ldata_q[{w_cap_idx, 3'b000} +: 8] <= mem_din;
            end
            rd_pend_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_start) begin
                        state_q <= ST_XFER;
                        idx_q   <= 3'd0;
                        store_q <= ma_we_in;   // we+re together counts as a store
                        width_q <= ma_width_in;
                        addr_q  <= ma_addr_in;
                        sdata_q <= ma_wdata_in;
                        waddr_q <= waddr_in;
                        ldata_q <= 32'd0;
                    end
                end
                ST_XFER: begin
                    if (mem_gnt) begin
                        idx_q     <= idx_q + 3'd1;
                        rd_pend_q <= ~store_q;
                        if (w_last) begin
                            state_q <= store_q ? ST_DONE : ST_TAIL;
                        end
                    end
                end
                ST_TAIL: state_q <= ST_DONE;
                default: state_q <= ST_IDLE;   // ST_DONE
            endcase
        end
    end

    always_comb begin
        we        = 1'b0;
        waddr     = 5'd0;
        wdata     = 32'd0;
        stall_req = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'd0;
        mem_dout  = 8'd0;
        misalign  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    misalign = w_req & w_misaligned;
                    if (w_req) begin
                        stall_req = ~w_misaligned;
                    end else begin
                        we    = we_in;
                        waddr = waddr_in;
                        wdata = wdata_in;
                    end
                end
                ST_XFER: begin
                    stall_req = 1'b1;
                    mem_req   = rdy;
                    mem_wr    = store_q;
                    mem_addr  = addr_q + {29'd0, idx_q};
                    mem_dout  = w_store_byte;
                end
                ST_TAIL: begin
                    stall_req = 1'b1;
                end
                default: begin  // ST_DONE
                    stall_req = ~rdy;
                    we        = ~store_q;
                    waddr     = store_q ? 5'd0  : waddr_q;
                    wdata     = store_q ? 32'd0 : w_ld_ext;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access. A transaction-level model
//            predicts every output each cycle. A byte-addressed memory model
//            acts as the arbiter. Directed transactions also carry literal
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        we_in;
    logic [4:0]  waddr_in;
    logic [31:0] wdata_in;
    logic        ma_we_in, ma_re_in;
    logic [2:0]  ma_width_in;
    logic [31:0] ma_addr_in, ma_wdata_in;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall_req, mem_req, mem_wr, mem_gnt, misalign;
    logic [31:0] mem_addr;
    logic [7:0]  mem_dout, mem_din;

    mem_access dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .we_in(we_in), .waddr_in(waddr_in), .wdata_in(wdata_in),
        .ma_we_in(ma_we_in), .ma_re_in(ma_re_in), .ma_width_in(ma_width_in),
        .ma_addr_in(ma_addr_in), .ma_wdata_in(ma_wdata_in),
        .we(we), .waddr(waddr), .wdata(wdata), .stall_req(stall_req),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .mem_gnt(mem_gnt), .mem_din(mem_din),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- memory and transaction model ----------------
    logic [7:0] mem [logic [31:0]];
    logic [7:0] rd_next = 8'hEE;

    typedef struct { logic [31:0] a; logic [7:0] d; } beat_t;
    beat_t       m_q[$];        // bytes still to be transferred, in order
    bit          m_busy, m_store, m_done, m_wait;
    logic [2:0]  m_width;
    logic [4:0]  m_waddr;
    logic [31:0] m_rdaddr, m_ld;
    int          m_nrx;
    logic [31:0] acc_addr[$];
    logic [31:0] last_wb;
    int          req_cyc, wb_cyc;

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [2:0] w);
        return (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic refused(input logic [2:0] w, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (nbytes(w) == 2 && a[0]) || (nbytes(w) == 4 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] w, input logic [31:0] v);
        case (w)
            3'b000:  return (v[7]  ? 32'hFFFFFF00 : 32'h0) | (v & 32'hFF);
            3'b001:  return (v[15] ? 32'hFFFF0000 : 32'h0) | (v & 32'hFFFF);
            3'b100:  return v & 32'hFF;
            3'b101:  return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    always @(negedge clk) begin
        logic        e_we, e_stall, e_req, e_wr, e_mis, req_in;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata, e_addr;
        logic [7:0]  e_dout;
        beat_t       b;
        cyc++;
        e_we = 0; e_stall = 0; e_req = 0; e_wr = 0; e_mis = 0;
        e_waddr = 0; e_wdata = 0; e_addr = 0; e_dout = 0;
        req_in = ma_we_in | ma_re_in;
        if (!rst) begin
            if (!m_busy) begin
                if (req_in) begin
                    if (refused(ma_width_in, ma_addr_in)) e_mis = 1;
                    else e_stall = 1;
                end else begin
                    e_we = we_in; e_waddr = waddr_in; e_wdata = wdata_in;
                end
            end else if (m_done) begin
                e_we    = !m_store;
                e_waddr = m_store ? 5'd0 : m_waddr;
                e_wdata = m_store ? 32'd0 : extend(m_width, m_ld);
                e_stall = !rdy;
            end else if (m_q.size() > 0) begin
                e_req = rdy; e_wr = m_store; e_addr = m_q[0].a; e_dout = m_q[0].d;
                e_stall = 1;
            end else begin
                e_stall = 1;
            end
        end
        check("we", 32'(we), 32'(e_we));
        check("waddr", 32'(waddr), 32'(e_waddr));
        check("wdata", wdata, e_wdata);
        check("stall_req", 32'(stall_req), 32'(e_stall));
        check("mem_req", 32'(mem_req), 32'(e_req));
        check("mem_wr", 32'(mem_wr), 32'(e_wr));
        check("mem_addr", mem_addr, e_addr);
        check("mem_dout", 32'(mem_dout), 32'(e_dout));
        check("misalign", 32'(misalign), 32'(e_mis));

        // arbiter / memory side, driven from what the model expects
        rd_next = 8'hEE;
        if (!rst && rdy && e_req && mem_gnt) begin
            acc_addr.push_back(e_addr);
            if (e_wr) mem[e_addr] = e_dout;
            else rd_next = rd(e_addr);
        end
        if (!rst && m_busy && m_done && !m_store) begin
            last_wb = wdata;
            wb_cyc  = cyc;
        end

        // advance model over the coming rising edge
        if (rst) begin
            m_busy = 0; m_done = 0; m_wait = 0; m_q.delete();
        end else if (rdy) begin
            if (!m_busy) begin
                if (req_in && !refused(ma_width_in, ma_addr_in)) begin
                    m_busy = 1; m_done = 0; m_wait = 0; m_store = ma_we_in;
                    m_width = ma_width_in; m_waddr = waddr_in; m_ld = 0; m_nrx = 0;
                    req_cyc = cyc;
                    for (int i = 0; i < nbytes(ma_width_in); i++) begin
                        b.a = ma_addr_in + 32'(i);
                        b.d = 8'(ma_wdata_in >> (8 * i));
                        m_q.push_back(b);
                    end
                end
            end else if (m_done) begin
                m_busy = 0; m_done = 0;
            end else begin
                if (m_wait) begin
                    m_ld   = m_ld | (32'(rd(m_rdaddr)) << (8 * m_nrx));
                    m_nrx++;
                    m_wait = 0;
                end
                if (m_q.size() > 0) begin
                    if (mem_gnt) begin
                        m_rdaddr = m_q[0].a;
                        m_wait   = !m_store;
                        void'(m_q.pop_front());
                        if (m_q.size() == 0 && m_store) m_done = 1;
                    end
                end else begin
                    m_done = 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1 mem_din = rd_next;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic st, input logic ld, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] wa);
        ma_we_in = st; ma_re_in = ld; ma_width_in = w;
        ma_addr_in = a; ma_wdata_in = d; waddr_in = wa;
        step();
        ma_we_in = 0; ma_re_in = 0;
    endtask

    task automatic finish_xfer();
        for (int k = 0; k < 40 && m_busy; k++) step();
        check("timeout", 32'(m_busy), 32'd0);
    endtask

    task automatic load(input logic [2:0] w, input logic [31:0] a, input logic [31:0] exp, input string nm);
        start(0, 1, w, a, 0, 5'd4);
        finish_xfer();
        check(nm, last_wb, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; rdy = 1; mem_gnt = 1; mem_din = 8'hEE;
        we_in = 1; waddr_in = 5'd7; wdata_in = 32'hCAFE;   // must be masked in reset
        ma_we_in = 0; ma_re_in = 1; ma_width_in = 3'b010;
        ma_addr_in = 32'h100; ma_wdata_in = 32'h1;
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem[32'h104] = 8'hAB; mem[32'h105] = 8'hCD;
        mem[32'h20]  = 8'h80;
        mem[32'h40]  = 8'h34; mem[32'h41]  = 8'hF2;
        mem[32'h60]  = 8'h11;
        repeat (3) step();
        check("rst_we", 32'(we), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        ma_re_in = 0;
        rst = 0;

        // ALU passthrough
        we_in = 1; waddr_in = 5'd5; wdata_in = 32'h1234;
        #1;
        check("pt_we", 32'(we), 32'd1);
        check("pt_waddr", 32'(waddr), 32'd5);
        check("pt_wdata", wdata, 32'h1234);
        check("pt_stall", 32'(stall_req), 32'd0);
        step();
        we_in = 0; wdata_in = 0;

        // LW, continuous grant
        acc_addr.delete();
        load(3'b010, 32'h100, 32'h12345678, "lw_value");
        check("lw_latency", 32'(wb_cyc - req_cyc), 32'd6);
        check("lw_nbeats", 32'(acc_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_addr.size(); i++)
            check("lw_addr", acc_addr[i], 32'h100 + 32'(i));

        // byte and halfword loads with extension
        load(3'b000, 32'h20, 32'hFFFFFF80, "lb_value");
        load(3'b100, 32'h20, 32'h00000080, "lbu_value");
        load(3'b001, 32'h40, 32'hFFFFF234, "lh_value");
        load(3'b101, 32'h40, 32'h0000F234, "lhu_value");

        // SH across the address wrap, second byte held off by the arbiter
        start(1, 0, 3'b001, 32'hFFFFFFFF, 32'hAABBCCDD, 5'd9);
        step();
        mem_gnt = 0;
        repeat (3) step();
        check("sh_hold_req", 32'(mem_req), 32'd1);
        check("sh_hold_addr", mem_addr, 32'h00000000);
        mem_gnt = 1;
        finish_xfer();
        check("sh_byte0", 32'(rd(32'hFFFFFFFF)), 32'hDD);
        check("sh_byte1", 32'(rd(32'h00000000)), 32'hCC);

        // we+re together is a store
        last_wb = 32'h5EED;
        start(1, 1, 3'b000, 32'h60, 32'h0000005A, 5'd2);
        finish_xfer();
        check("both_is_store", 32'(rd(32'h60)), 32'h5A);
        check("store_no_wb", last_wb, 32'h5EED);

        // SW with rdy dropped mid-transfer
        start(1, 0, 3'b010, 32'h200, 32'hDEADBEEF, 5'd1);
        step();
        rdy = 0;
        repeat (2) step();
        check("rdy_low_stall", 32'(stall_req), 32'd1);
        check("rdy_low_req", 32'(mem_req), 32'd0);
        rdy = 1;
        finish_xfer();
        check("sw_word", {rd(32'h203), rd(32'h202), rd(32'h201), rd(32'h200)}, 32'hDEADBEEF);

        // reset in the middle of a LW
        last_wb = 32'h5EED;
        start(0, 1, 3'b010, 32'h100, 0, 5'd6);
        step();
        rst = 1;
        step();
        rst = 0;
        check("rst_mid_req", 32'(mem_req), 32'd0);
        check("rst_mid_stall", 32'(stall_req), 32'd0);
        repeat (8) step();
        check("rst_mid_no_wb", last_wb, 32'h5EED);

        // misaligned word load
`ifdef MEM_ALIGN_CHECK_EN
        ma_re_in = 1; ma_width_in = 3'b010; ma_addr_in = 32'h102; waddr_in = 5'd3;
        #1;
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_req", 32'(mem_req), 32'd0);
        check("mis_we", 32'(we), 32'd0);
        check("mis_stall", 32'(stall_req), 32'd0);
        step();
        ma_re_in = 0;
        step();
        check("mis_stays_idle", 32'(stall_req), 32'd0);
`else
        load(3'b010, 32'h102, 32'hCDAB1234, "lw_unaligned");
`endif

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
